// File: rtl/d_delay_var.sv
// d_delay_var -- runtime-variable multi-bit delay line with valid tracking.
//
// Re-aligns a {valid, data} stream by a delay chosen at run time
// (0..MaxDelay enabled cycles). A delay of 0 is a combinational bypass.
// A delay change or a clear discards every sample in flight, so a sample is
// never duplicated or shown at the wrong delay. settled_o reports that the
// line has been primed at the current delay.
//
// Parameters:
//   Bits      data width
//   MaxDelay  largest supported delay (>= 1); larger requests saturate
//   DelW      width of delay_i
//
// Ports:
//   clk_i      clock
//   rst_i      synchronous active-high reset
//   en_i       advance enable; the line holds when low
//   clear_i    synchronous flush of in-flight samples
//   delay_i    requested delay
//   valid_i    input sample qualifier
//   data_i     input sample
//   valid_o    output sample qualifier
//   data_o     output sample (don't-care while valid_o = 0)
//   settled_o  line fully primed at the current delay
//
// Build option:
//   D_DELAY_VAR_RESET_DATA_EN  when defined, stage data is zeroed on rst_i
//                              and on clear_i. When undefined, data stages
//                              have no reset and can map to shift-register
//                              primitives. valid_o behaves the same either way.

module d_delay_var #(
  parameter int Bits     = 8,
  parameter int MaxDelay = 16,
  parameter int DelW     = $clog2(MaxDelay + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic            clear_i,
  input  logic [DelW-1:0] delay_i,
  input  logic            valid_i,
  input  logic [Bits-1:0] data_i,
  output logic            valid_o,
  output logic [Bits-1:0] data_o,
  output logic            settled_o
);

  localparam int              IdxW = (MaxDelay > 1) ? $clog2(MaxDelay) : 1;
  localparam logic [DelW-1:0] MaxD = DelW'(MaxDelay);
  localparam logic [DelW-1:0] One  = DelW'(1);

  logic [DelW-1:0]     sat_delay;
  logic [DelW-1:0]     cur_delay;
  logic [DelW-1:0]     cnt;
  logic                delay_chg;
  logic [IdxW-1:0]     tap;
  logic [MaxDelay-1:0] valid_q;
  logic [Bits-1:0]     data_q [MaxDelay];

  assign sat_delay = (delay_i > MaxD) ? MaxD : delay_i;
  assign delay_chg = (sat_delay != cur_delay);

  // Control state: current delay, per-stage valid bits, warm-up counter.
  // NOTE: state registers use non-blocking assignments so every stage
  // samples its neighbour's pre-edge value and the shift is order-independent.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cur_delay <= '0;
      cnt       <= '0;
      valid_q   <= '0;
    end else begin
      // cur_delay tracks the request on every non-reset edge, clear included.
      cur_delay <= sat_delay;
      if (clear_i) begin
        valid_q <= '0;
        cnt     <= '0;
      end else if (delay_chg) begin
        // Samples in flight were timed for the old delay: drop them all.
        // Only the sample arriving on this edge survives.
        valid_q    <= '0;
        valid_q[0] <= en_i & valid_i;
        cnt        <= '0;
      end else if (en_i) begin
        valid_q[0] <= valid_i;
        for (int k = 1; k < MaxDelay; k++) valid_q[k] <= valid_q[k-1];
        if (cnt != MaxD) cnt <= cnt + One;
      end
    end
  end

  // NOTE: data stages are a memory-like array; whether they get a reset is a
  // build-time choice, because the valid bits alone decide what is real data.
`ifdef D_DELAY_VAR_RESET_DATA_EN
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      for (int k = 0; k < MaxDelay; k++) data_q[k] <= '0;
    end else if (en_i) begin
      data_q[0] <= data_i;
      for (int k = 1; k < MaxDelay; k++) data_q[k] <= data_q[k-1];
    end
  end
`else
  // Plain enable-only shift so the chain can pack into shift-register cells.
  // Shifting across a delay change is harmless: those stages are marked invalid.
  always_ff @(posedge clk_i) begin
    if (en_i && !clear_i && !rst_i) begin
      data_q[0] <= data_i;
      for (int k = 1; k < MaxDelay; k++) data_q[k] <= data_q[k-1];
    end
  end
`endif

  // Output tap: stage cur_delay-1, or the input itself when the delay is 0.
  assign tap = IdxW'(cur_delay - One);

  always_comb begin
    valid_o   = valid_i;
    data_o    = data_i;
    settled_o = 1'b1;
    if (cur_delay != '0) begin
      valid_o   = valid_q[tap];
      data_o    = data_q[tap];
      settled_o = (cnt >= cur_delay);
    end
  end

endmodule

// File: tb/tb_d_delay_var.sv
// Self-checking bench for d_delay_var (Bits=8, MaxDelay=16).
// A queue-based model records every sample accepted since the last flush and
// predicts the outputs; a negedge process compares DUT against it each cycle.
// Directed literal checks pin the model to hand-computed values.

module tb_d_delay_var;

  localparam int Bits     = 8;
  localparam int MaxDelay = 16;
  localparam int DelW     = $clog2(MaxDelay + 1);

  logic            clk;
  logic            rst;
  logic            en;
  logic            clear;
  logic [DelW-1:0] delay;
  logic            vin;
  logic [Bits-1:0] din;
  logic            valid_o;
  logic [Bits-1:0] data_o;
  logic            settled_o;

  int n_tests = 0;
  int n_fail  = 0;

  d_delay_var #(.Bits(Bits), .MaxDelay(MaxDelay), .DelW(DelW)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .en_i     (en),
    .clear_i  (clear),
    .delay_i  (delay),
    .valid_i  (vin),
    .data_i   (din),
    .valid_o  (valid_o),
    .data_o   (data_o),
    .settled_o(settled_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic            v;
    logic [Bits-1:0] d;
  } samp_t;

  samp_t hist[$];      // samples accepted since the last flush, oldest first
  int    m_cur   = 0;  // delay in force
  int    m_cnt   = 0;  // enabled edges since flush, saturating
  int    m_req   = 0;
  bit    armed   = 1'b0;

  always @(posedge clk) begin
    m_req = (int'(delay) > MaxDelay) ? MaxDelay : int'(delay);
    if (rst) begin
      hist.delete();
      m_cur = 0;
      m_cnt = 0;
      armed = 1'b1;
    end else begin
      if (clear) begin
        hist.delete();
        m_cnt = 0;
      end else if (m_req != m_cur) begin
        hist.delete();
        m_cnt = 0;
        if (en) hist.push_back('{vin, din});
      end else if (en) begin
        hist.push_back('{vin, din});
        if (hist.size() > MaxDelay) void'(hist.pop_front());
        if (m_cnt < MaxDelay) m_cnt++;
      end
      m_cur = m_req;
    end
  end

  // ---------------- per-cycle compare ----------------
  samp_t e_s;
  logic  e_v;
  logic  e_set;

  always @(negedge clk) begin
    if (armed) begin
      if (m_cur == 0) begin
        e_s   = '{vin, din};
        e_set = 1'b1;
      end else begin
        e_s   = (hist.size() >= m_cur) ? hist[hist.size() - m_cur] : '{1'b0, '0};
        e_set = (m_cnt >= m_cur);
      end
      e_v = e_s.v;
      check("model valid_o", 32'(valid_o), 32'(e_v));
      if (e_v) check("model data_o", 32'(data_o), 32'(e_s.d));
      check("model settled_o", 32'(settled_o), 32'(e_set));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clear = 1'b0; delay = '0; vin = 1'b0; din = '0;
    tick();
    tick();
    check("reset valid_o", 32'(valid_o), 32'd0);
    check("reset settled_o", 32'(settled_o), 32'd1);
    rst = 1'b0;

    // Delay 5, samples 1..10.
    delay = 5'd5; en = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      vin = 1'b1; din = 8'(k);
      tick();
      if (k == 5) begin
        check("d5 first data", 32'(data_o), 32'h01);
        check("d5 first valid", 32'(valid_o), 32'd1);
        check("d5 settled low", 32'(settled_o), 32'd0);
      end
      if (k == 6) begin
        check("d5 second data", 32'(data_o), 32'h02);
        check("d5 settled high", 32'(settled_o), 32'd1);
      end
    end
    vin = 1'b0; din = 8'hEE;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 0) check("d5 drain data", 32'(data_o), 32'h07);
    end

    // Stall for 3 cycles mid-stream; disabled edges add no latency.
    for (int i = 0; i < 9; i++) begin
      if (i >= 3 && i <= 5) begin
        en = 1'b0; vin = 1'b1; din = 8'hEE;
      end else begin
        en = 1'b1; vin = 1'b1; din = 8'h11 + 8'((i < 3) ? i : i - 3);
      end
      tick();
      if (i == 6) check("stall pre valid", 32'(valid_o), 32'd0);
      if (i == 7) check("stall first data", 32'(data_o), 32'h11);
    end
    en = 1'b1; vin = 1'b0;
    for (int k = 0; k < 6; k++) tick();

    // Four samples in flight at delay 5, then switch to 3.
    for (int k = 0; k < 4; k++) begin
      vin = 1'b1; din = 8'h21 + 8'(k);
      tick();
    end
    delay = 5'd3; din = 8'h25;
    tick();
    check("chg valid low", 32'(valid_o), 32'd0);
    check("chg settled low", 32'(settled_o), 32'd0);
    din = 8'h26; tick();
    din = 8'h27; tick();
    check("chg first data", 32'(data_o), 32'h25);
    check("chg first valid", 32'(valid_o), 32'd1);
    check("chg settled still low", 32'(settled_o), 32'd0);
    din = 8'h28; tick();
    check("chg settled high", 32'(settled_o), 32'd1);
    check("chg second data", 32'(data_o), 32'h26);
    vin = 1'b0;
    for (int k = 0; k < 3; k++) tick();

    // Delay 0: combinational bypass.
    delay = 5'd0;
    tick();
    vin = 1'b1; din = 8'h5A;
    #1;
    check("bypass data", 32'(data_o), 32'h5A);
    check("bypass valid", 32'(valid_o), 32'd1);
    check("bypass settled", 32'(settled_o), 32'd1);
    for (int k = 0; k < 4; k++) begin
      vin = k[0]; din = 8'hC0 ^ 8'(k * 37);
      tick();
    end

    // Delay 31 saturates to 16.
    delay = 5'd31;
    for (int i = 0; i <= 17; i++) begin
      vin = 1'b1; din = 8'h80 + 8'(i);
      tick();
      if (i == 14) check("sat not yet", 32'(valid_o), 32'd0);
      if (i == 15) begin
        check("sat first data", 32'(data_o), 32'h80);
        check("sat settled low", 32'(settled_o), 32'd0);
      end
      if (i == 16) begin
        check("sat second data", 32'(data_o), 32'h81);
        check("sat settled high", 32'(settled_o), 32'd1);
      end
    end

    // Clear with samples in flight at delay 4.
    delay = 5'd4;
    for (int k = 0; k < 4; k++) begin
      vin = 1'b1; din = 8'h91 + 8'(k);
      tick();
    end
    clear = 1'b1; din = 8'h95;
    tick();
    check("clear valid", 32'(valid_o), 32'd0);
    check("clear settled", 32'(settled_o), 32'd0);
    clear = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      vin = (j == 1); din = (j == 1) ? 8'h77 : 8'hEE;
      tick();
      if (j == 3) check("clear pre valid", 32'(valid_o), 32'd0);
      if (j == 4) begin
        check("clear next data", 32'(data_o), 32'h77);
        check("clear next valid", 32'(valid_o), 32'd1);
        check("clear settled back", 32'(settled_o), 32'd1);
      end
    end

    // Reset mid-stream.
    for (int k = 0; k < 5; k++) begin
      vin = 1'b1; din = 8'hA1 + 8'(k);
      tick();
    end
    rst = 1'b1; vin = 1'b0; din = '0;
    tick();
    check("midrst valid", 32'(valid_o), 32'd0);
`ifdef D_DELAY_VAR_RESET_DATA_EN
    check("midrst data", 32'(data_o), 32'd0);
`endif
    rst = 1'b0; en = 1'b0; delay = 5'd4; vin = 1'b1; din = 8'h33;
    tick();
    check("postrst tap valid", 32'(valid_o), 32'd0);
`ifdef D_DELAY_VAR_RESET_DATA_EN
    check("postrst tap data", 32'(data_o), 32'd0);
`endif
    en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      vin = 1'b1; din = 8'hB0 + 8'(k);
      tick();
    end
    vin = 1'b0;
    for (int k = 0; k < 5; k++) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
